// File: rtl/stopwatch_pkg.sv
// Shared constants and FSM encoding for the stopwatch controller.
// Optional lap-hold feature is enabled with `define STOPWATCH_LAP_EN.
package stopwatch_pkg;
  localparam int DIV_W   = 32;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;
endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every div enabled cycles.
// The count holds while en is low and is zeroed by restart.
module tick_gen #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] r_pre;
  logic             w_last;

  // div is never below 1, so div-1 cannot underflow
  assign w_last = (r_pre >= div - DIV_W'(1));
  assign tick   = en & ~restart & w_last;

  always_ff @(posedge clk) begin
    if (rst || restart) r_pre <= '0;
    else if (en)        r_pre <= w_last ? '0 : r_pre + DIV_W'(1);
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/clear stopwatch: button edge detect, IDLE/RUN/PAUSE FSM, MM:SS counters.
// `define STOPWATCH_LAP_EN adds btn_lap, which freezes the displayed time while counting continues.
module stopwatch_ctrl #(
  parameter int DIV_W   = stopwatch_pkg::DIV_W,
  parameter int SEC_MAX = stopwatch_pkg::SEC_MAX,
  parameter int MIN_MAX = stopwatch_pkg::MIN_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] num,
  input  logic             btn_start_stop,
  input  logic             btn_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic             btn_lap,
`endif
  output logic [5:0]       sec_out,
  output logic [5:0]       min_out,
  output logic             running,
  output logic             tick_o,
  output logic             ovf
);
  import stopwatch_pkg::*;

  sw_state_e        r_state, w_state_nxt;
  logic             r_ss_q, r_clr_q;
  logic             w_ss_edge, w_clr_edge, w_start, w_en, w_tick;
  logic [DIV_W-1:0] r_div;
  logic [5:0]       r_sec, r_min;
  logic             r_running, r_tick, r_ovf;

  assign w_ss_edge  = btn_start_stop & ~r_ss_q;
  assign w_clr_edge = btn_clear & ~r_clr_q;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    if (w_clr_edge) begin
      w_state_nxt = IDLE;
    end else if (w_ss_edge) begin
      case (r_state)
        IDLE:    begin w_state_nxt = RUN; w_start = 1'b1; end
        RUN:     w_state_nxt = PAUSE;
        PAUSE:   w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Prescaler only advances on cycles that stay in RUN, so a pause edge freezes it
  assign w_en = (r_state == RUN) && (w_state_nxt == RUN);

  tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (w_en),
    .restart (w_start | w_clr_edge),
    .div     (r_div),
    .tick    (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ss_q    <= 1'b0;
      r_clr_q   <= 1'b0;
      r_div     <= DIV_W'(1);
      r_sec     <= '0;
      r_min     <= '0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ss_q    <= btn_start_stop;
      r_clr_q   <= btn_clear;
      r_running <= (w_state_nxt == RUN);
      r_tick    <= w_tick;
      if (w_start) r_div <= (num < DIV_W'(2)) ? DIV_W'(1) : num;
      if (w_clr_edge) begin
        r_sec <= '0;
        r_min <= '0;
        r_ovf <= 1'b0;
      end else if (w_tick) begin
        if (r_sec == 6'(SEC_MAX)) begin
          r_sec <= '0;
          if (r_min == 6'(MIN_MAX)) begin
            r_min <= '0;
            r_ovf <= 1'b1;
          end else begin
            r_min <= r_min + 6'd1;
          end
        end else begin
          r_sec <= r_sec + 6'd1;
        end
      end
    end
  end

  assign running = r_running;
  assign tick_o  = r_tick;
  assign ovf     = r_ovf;

`ifdef STOPWATCH_LAP_EN
  logic       r_lap_q, r_hold, w_lap_edge;
  logic [5:0] r_lap_sec, r_lap_min;

  assign w_lap_edge = btn_lap & ~r_lap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lap_q   <= 1'b0;
      r_hold    <= 1'b0;
      r_lap_sec <= '0;
      r_lap_min <= '0;
    end else begin
      r_lap_q <= btn_lap;
      if (w_clr_edge) begin
        r_hold <= 1'b0;
      end else if (w_lap_edge && r_state == RUN) begin
        r_hold    <= ~r_hold;
        r_lap_sec <= r_sec;
        r_lap_min <= r_min;
      end
    end
  end

  assign sec_out = r_hold ? r_lap_sec : r_sec;
  assign min_out = r_hold ? r_lap_min : r_min;
`else
  assign sec_out = r_sec;
  assign min_out = r_min;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: vector table plus hand sequences feeding a scoreboard.
module tb_stopwatch_ctrl;
  logic        clk = 1'b0;
  logic        rst, btn_start_stop, btn_clear;
  logic [31:0] num;
  logic [5:0]  sec_out, min_out;
  logic        running, tick_o, ovf;
`ifdef STOPWATCH_LAP_EN
  logic        btn_lap;
`endif

  always #5 clk = ~clk;

  stopwatch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .num            (num),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
`ifdef STOPWATCH_LAP_EN
    .btn_lap        (btn_lap),
`endif
    .sec_out        (sec_out),
    .min_out        (min_out),
    .running        (running),
    .tick_o         (tick_o),
    .ovf            (ovf)
  );

  typedef struct {
    string      nm;
    logic [5:0] sec, min;
    logic       run, tick, ov;
  } exp_t;

  typedef struct {
    string       nm;
    logic        ss, clr;
    logic [31:0] n;
    int          cyc;
    logic [5:0]  sec, min;
    logic        run, tick, ov;
  } vec_t;

  exp_t sb[$];
  vec_t vt[15];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(string nm, bit ss, bit clr, int n, int cyc,
                              int s, int m, bit r, bit t, bit o);
    vec_t v;
    v.nm = nm; v.ss = ss; v.clr = clr; v.n = n; v.cyc = cyc;
    v.sec = 6'(s); v.min = 6'(m); v.run = r; v.tick = t; v.ov = o;
    return v;
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(string nm, int s, int m, bit r, bit t, bit o);
    exp_t e;
    e.nm = nm; e.sec = 6'(s); e.min = 6'(m); e.run = r; e.tick = t; e.ov = o;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if ({sec_out, min_out, running, tick_o, ovf} !== {e.sec, e.min, e.run, e.tick, e.ov}) begin
        n_err++;
        $display("FAIL %s: got %0d:%0d run=%b tick=%b ovf=%b, want %0d:%0d run=%b tick=%b ovf=%b",
                 e.nm, min_out, sec_out, running, tick_o, ovf,
                 e.min, e.sec, e.run, e.tick, e.ov);
      end
    end
  endtask

  task automatic run_step(string nm, int n, int s, int m, bit r, bit t, bit o);
    push(nm, s, m, r, t, o);
    step(n);
    drain();
  endtask

  initial begin
    rst = 1'b1; btn_start_stop = 1'b0; btn_clear = 1'b0; num = 32'd5;
`ifdef STOPWATCH_LAP_EN
    btn_lap = 1'b0;
`endif
    run_step("reset_held", 2, 0, 0, 0, 0, 0);
    rst = 1'b0;
    run_step("reset_released", 1, 0, 0, 0, 0, 0);

    // num=5: start at E1, ticks at E6, E11, E16, ...; num changed mid-run is ignored
    vt[0]  = mk("start",          1, 0, 5, 1,  0, 0, 1, 0, 0);
    vt[1]  = mk("pre_first_tick", 0, 0, 5, 4,  0, 0, 1, 0, 0);
    vt[2]  = mk("first_tick",     0, 0, 5, 1,  1, 0, 1, 1, 0);
    vt[3]  = mk("tick_one_cycle", 0, 0, 9, 1,  1, 0, 1, 0, 0);
    vt[4]  = mk("period_stays_5", 0, 0, 9, 4,  2, 0, 1, 1, 0);
    vt[5]  = mk("sec3_at_15",     0, 0, 9, 5,  3, 0, 1, 1, 0);
    vt[6]  = mk("sec4_pre2",      0, 0, 9, 7,  4, 0, 1, 0, 0);
    vt[7]  = mk("pause",          1, 0, 9, 1,  4, 0, 0, 0, 0);
    vt[8]  = mk("pause_hold20",   0, 0, 9, 20, 4, 0, 0, 0, 0);
    vt[9]  = mk("resume",         1, 0, 9, 1,  4, 0, 1, 0, 0);
    vt[10] = mk("resume_no_tick", 0, 0, 9, 2,  4, 0, 1, 0, 0);
    vt[11] = mk("resume_tick_3",  0, 0, 9, 1,  5, 0, 1, 1, 0);
    vt[12] = mk("clear_priority", 1, 1, 9, 1,  0, 0, 0, 0, 0);
    vt[13] = mk("held_buttons",   1, 1, 9, 3,  0, 0, 0, 0, 0);
    vt[14] = mk("idle_released",  0, 0, 9, 1,  0, 0, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      btn_start_stop = vt[i].ss;
      btn_clear      = vt[i].clr;
      num            = vt[i].n;
      run_step(vt[i].nm, vt[i].cyc, vt[i].sec, vt[i].min, vt[i].run, vt[i].tick, vt[i].ov);
    end

    // num=0 behaves as a divisor of 1: tick every RUN cycle
    num = 32'd0; btn_start_stop = 1'b1;
    run_step("n0_start", 1, 0, 0, 1, 0, 0);
    btn_start_stop = 1'b0;
    for (int k = 1; k <= 5; k++) run_step("n0_tick", 1, k, 0, 1, 1, 0);
    btn_clear = 1'b1;
    run_step("n0_clear", 1, 0, 0, 0, 0, 0);
    btn_clear = 1'b0;

    // Full wrap with num=1
    num = 32'd1; btn_start_stop = 1'b1;
    run_step("wrap_start", 1, 0, 0, 1, 0, 0);
    btn_start_stop = 1'b0;
    run_step("at_59_59", 3599, 59, 59, 1, 1, 0);
    run_step("wrap_00_00", 1, 0, 0, 1, 1, 1);
    run_step("after_wrap_01_01", 61, 1, 1, 1, 1, 1);
    btn_clear = 1'b1;
    run_step("clear_ovf", 1, 0, 0, 0, 0, 0);
    btn_clear = 1'b0;

    // Synchronous reset mid-run
    btn_start_stop = 1'b1;
    run_step("rst_prep_start", 1, 0, 0, 1, 0, 0);
    btn_start_stop = 1'b0;
    run_step("rst_prep_count", 3, 3, 0, 1, 1, 0);
    rst = 1'b1;
    run_step("rst_mid_run", 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    run_step("rst_after", 1, 0, 0, 0, 0, 0);

`ifdef STOPWATCH_LAP_EN
    num = 32'd1; btn_start_stop = 1'b1;
    run_step("lap_start", 1, 0, 0, 1, 0, 0);
    btn_start_stop = 1'b0;
    run_step("lap_at_7", 7, 7, 0, 1, 1, 0);
    btn_lap = 1'b1;
    run_step("lap_freeze", 1, 7, 0, 1, 1, 0);
    btn_lap = 1'b0;
    run_step("lap_held", 3, 7, 0, 1, 1, 0);
    btn_lap = 1'b1;
    run_step("lap_release_12", 1, 12, 0, 1, 1, 0);
    btn_lap = 1'b0;
    run_step("lap_live", 1, 13, 0, 1, 1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
